// File: rtl/tone_sequencer.sv
// Note recorder / playback scheduler that drives the tone generator half-period.
// Ports: clk, reset (async high), keyb_char, rec, play, clear -> period, busy, count, full. Macro: TONE_SEQ_LOOP_EN.
module tone_sequencer #(
  parameter int NOTE_CYCLES = 25_000_000,
  parameter int GAP_CYCLES  = 2_500_000,
  parameter int DEPTH       = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            keyb_char,
  input  logic                   rec,
  input  logic                   play,
  input  logic                   clear,
  output logic [31:0]            period,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = AW + 1;
  localparam int TMAX = (NOTE_CYCLES > GAP_CYCLES) ? NOTE_CYCLES : GAP_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] NOTE_LAST = TW'(NOTE_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PLAY_NOTE = 2'd1,
    PLAY_GAP  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   rd_q, rd_d;
  logic [CW-1:0]   count_q, count_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [31:0]     period_q, period_d;
  logic [31:0]     key_q;
  logic            play_q;
  logic [2:0]      mem_q [DEPTH];
  logic            wr_en;

  logic [3:0]      key_hit;
  logic [31:0]     live_per;
  logic            press;
  logic            play_rise;
  logic            last;
  logic            full_w;

  // {mapped, index}
  function automatic logic [3:0] key_map(input logic [31:0] k);
    case (k)
      32'h15:  key_map = 4'b1_000;
      32'h1D:  key_map = 4'b1_001;
      32'h24:  key_map = 4'b1_010;
      32'h2D:  key_map = 4'b1_011;
      32'h2C:  key_map = 4'b1_100;
      32'h35:  key_map = 4'b1_101;
      32'h3C:  key_map = 4'b1_110;
      32'h43:  key_map = 4'b1_111;
      default: key_map = 4'b0_000;
    endcase
  endfunction

  function automatic logic [31:0] note_period(input logic [2:0] idx);
    case (idx)
      3'd0:    note_period = 32'd382219;
      3'd1:    note_period = 32'd340530;
      3'd2:    note_period = 32'd303370;
      3'd3:    note_period = 32'd286344;
      3'd4:    note_period = 32'd255102;
      3'd5:    note_period = 32'd227273;
      3'd6:    note_period = 32'd202478;
      default: note_period = 32'd191113;
    endcase
  endfunction

  assign key_hit   = key_map(keyb_char);
  assign live_per  = key_hit[3] ? note_period(key_hit[2:0]) : 32'd0;
  // Edge against last cycle's code so a held key records only once.
  assign press     = key_hit[3] && (keyb_char != key_q);
  assign play_rise = play && !play_q;
  assign full_w    = (count_q == CW'(DEPTH));
  assign last      = ({1'b0, rd_q} == (count_q - CW'(1)));

  always_comb begin
    state_d  = state_q;
    rd_d     = rd_q;
    count_d  = count_q;
    timer_d  = timer_q;
    period_d = period_q;
    wr_en    = 1'b0;
    if (clear) begin
      state_d  = IDLE;
      rd_d     = '0;
      count_d  = '0;
      timer_d  = '0;
      period_d = live_per;
    end else begin
      unique case (state_q)
        IDLE: begin
          period_d = live_per;
          timer_d  = '0;
          if (press && rec && !full_w) begin
            wr_en   = 1'b1;
            count_d = count_q + CW'(1);
          end
          if (play_rise && (count_q != '0)) begin
            state_d  = PLAY_NOTE;
            rd_d     = '0;
            period_d = note_period(mem_q[0]);
          end
        end
        PLAY_NOTE: begin
          if (timer_q == NOTE_LAST) begin
            state_d  = PLAY_GAP;
            timer_d  = '0;
            period_d = '0;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        PLAY_GAP: begin
          if (timer_q == GAP_LAST) begin
            timer_d = '0;
            if (last) begin
`ifdef TONE_SEQ_LOOP_EN
              if (play) begin
                state_d  = PLAY_NOTE;
                rd_d     = '0;
                period_d = note_period(mem_q[0]);
              end else begin
                state_d  = IDLE;
                period_d = live_per;
              end
`else
              state_d  = IDLE;
              period_d = live_per;
`endif
            end else begin
              state_d  = PLAY_NOTE;
              rd_d     = rd_q + AW'(1);
              period_d = note_period(mem_q[rd_q + AW'(1)]);
            end
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      rd_q     <= '0;
      count_q  <= '0;
      timer_q  <= '0;
      period_q <= '0;
      key_q    <= '0;
      play_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_q     <= rd_d;
      count_q  <= count_d;
      timer_q  <= timer_d;
      period_q <= period_d;
      key_q    <= keyb_char;
      play_q   <= play;
    end
  end

  // Contents are don't-care after reset since count restarts at 0.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[count_q[AW-1:0]] <= key_hit[2:0];
  end

  assign period = period_q;
  assign busy   = (state_q != IDLE);
  assign count  = count_q;
  assign full   = full_w;

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed self-checking bench for tone_sequencer (NOTE=4, GAP=2, DEPTH=4).
// Loop checks follow TONE_SEQ_LOOP_EN when defined.
module tb_tone_sequencer;

  logic        clk;
  logic        reset;
  logic [31:0] keyb_char;
  logic        rec;
  logic        play;
  logic        clear;
  logic [31:0] period;
  logic        busy;
  logic [2:0]  count;
  logic        full;

  int passed = 0;
  int total  = 0;

  tone_sequencer #(
    .NOTE_CYCLES(4),
    .GAP_CYCLES (2),
    .DEPTH      (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .keyb_char (keyb_char),
    .rec       (rec),
    .play      (play),
    .clear     (clear),
    .period    (period),
    .busy      (busy),
    .count     (count),
    .full      (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask

  task automatic press(input logic [31:0] k);
    keyb_char = k;
    tick(1);
    keyb_char = 32'h0;
    tick(1);
  endtask

  initial begin
    logic [31:0] tbl [3];
    logic [31:0] exp_p;

    reset = 1'b1;
    keyb_char = 32'h0;
    rec = 1'b0;
    play = 1'b0;
    clear = 1'b0;
    tick(2);
    chk("rst_period", period, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_count", {29'd0, count}, 0);
    chk("rst_full", {31'd0, full}, 0);
    reset = 1'b0;
    tick(1);

    // live pass-through
    keyb_char = 32'h24;
    chk("live_pre", period, 0);
    tick(1);
    chk("live_on", period, 303370);
    keyb_char = 32'h0;
    tick(1);
    chk("live_off", period, 0);
    chk("live_count", {29'd0, count}, 0);

    // record q, e, i
    rec = 1'b1;
    keyb_char = 32'h15;
    tick(1);
    chk("rec_cnt1", {29'd0, count}, 1);
    keyb_char = 32'h0;
    tick(1);
    press(32'h24);
    press(32'h43);
    rec = 1'b0;
    chk("rec_cnt3", {29'd0, count}, 3);
    chk("rec_full0", {31'd0, full}, 0);

    // play; disturb with live key and a second play edge
    tbl[0] = 32'd382219;
    tbl[1] = 32'd303370;
    tbl[2] = 32'd191113;
    play = 1'b1;
    tick(1);
    chk("play_busy0", {31'd0, busy}, 1);
    chk("play_per0", period, 382219);
    play = 1'b0;
    for (int i = 1; i < 18; i++) begin
      if (i == 2) keyb_char = 32'h43;
      if (i == 3) play = 1'b1;
      if (i == 4) play = 1'b0;
      tick(1);
      exp_p = ((i % 6) < 4) ? tbl[i / 6] : 32'd0;
      chk($sformatf("play_per%0d", i), period, exp_p);
      chk($sformatf("play_busy%0d", i), {31'd0, busy}, 1);
    end
    tick(1);
    chk("play_end_busy", {31'd0, busy}, 0);
    chk("play_end_live", period, 191113);
    chk("play_end_cnt", {29'd0, count}, 3);
    keyb_char = 32'h0;
    tick(1);

    // held key then fill
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    chk("clr_cnt", {29'd0, count}, 0);
    rec = 1'b1;
    keyb_char = 32'h15;
    tick(10);
    chk("hold_cnt", {29'd0, count}, 1);
    keyb_char = 32'h0;
    tick(1);
    press(32'h1D);
    press(32'h24);
    chk("fill_cnt3", {29'd0, count}, 3);
    chk("fill_full0", {31'd0, full}, 0);
    press(32'h2D);
    chk("fill_cnt4", {29'd0, count}, 4);
    chk("fill_full1", {31'd0, full}, 1);
    press(32'h2C);
    chk("drop_cnt", {29'd0, count}, 4);
    chk("drop_full", {31'd0, full}, 1);
    rec = 1'b0;

    // priority then clear mid-note
    play = 1'b1;
    tick(1);
    chk("pri_busy", {31'd0, busy}, 1);
    chk("pri_per0", period, 382219);
    play = 1'b0;
    keyb_char = 32'h35;
    tick(1);
    chk("pri_per1", period, 382219);
    tick(1);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    chk("clr_per", period, 227273);
    chk("clr_busy", {31'd0, busy}, 0);
    chk("clr_count", {29'd0, count}, 0);
    chk("clr_full", {31'd0, full}, 0);
    keyb_char = 32'h0;
    tick(1);

    // empty play
    play = 1'b1;
    tick(1);
    chk("empty_busy", {31'd0, busy}, 0);
    chk("empty_per", period, 0);
    play = 1'b0;
    tick(1);

    // async reset mid-note
    rec = 1'b1;
    press(32'h3C);
    rec = 1'b0;
    chk("rr_cnt", {29'd0, count}, 1);
    play = 1'b1;
    tick(1);
    chk("rr_busy", {31'd0, busy}, 1);
    chk("rr_per", period, 202478);
    play = 1'b0;
    tick(1);
    #2 reset = 1'b1;
    #1;
    chk("arst_per", period, 0);
    chk("arst_busy", {31'd0, busy}, 0);
    chk("arst_cnt", {29'd0, count}, 0);
    chk("arst_full", {31'd0, full}, 0);
    tick(1);
    reset = 1'b0;
    tick(1);

    // two notes with play held
    rec = 1'b1;
    press(32'h15);
    press(32'h1D);
    rec = 1'b0;
    chk("loop_cnt", {29'd0, count}, 2);
    tbl[0] = 32'd382219;
    tbl[1] = 32'd340530;
    play = 1'b1;
    tick(1);
    chk("loop_per0", period, 382219);
`ifdef TONE_SEQ_LOOP_EN
    for (int i = 1; i < 24; i++) begin
      if (i == 20) play = 1'b0;
      tick(1);
      exp_p = ((i % 6) < 4) ? tbl[(i / 6) % 2] : 32'd0;
      chk($sformatf("loop_per%0d", i), period, exp_p);
      chk($sformatf("loop_busy%0d", i), {31'd0, busy}, 1);
    end
    tick(1);
    chk("loop_end_busy", {31'd0, busy}, 0);
    chk("loop_end_per", period, 0);
`else
    for (int i = 1; i < 12; i++) begin
      tick(1);
      exp_p = ((i % 6) < 4) ? tbl[i / 6] : 32'd0;
      chk($sformatf("once_per%0d", i), period, exp_p);
      chk($sformatf("once_busy%0d", i), {31'd0, busy}, 1);
    end
    tick(1);
    chk("once_end_busy", {31'd0, busy}, 0);
    chk("once_end_per", period, 0);
    tick(4);
    chk("once_stay_busy", {31'd0, busy}, 0);
    chk("once_stay_per", period, 0);
`endif
    play = 1'b0;
    tick(1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
